// File: rtl/core_dbg_pkg.sv
// Shared definitions for the run/debug controller.
// Holds the host command encodings, halt cause encodings, controller state
// enum and the EBREAK instruction word.
package core_dbg_pkg;

  typedef enum logic [2:0] {
    OP_NOP    = 3'd0,
    OP_RUN    = 3'd1,
    OP_HALT   = 3'd2,
    OP_STEP   = 3'd3,
    OP_SET_BP = 3'd4,
    OP_CLR_BP = 3'd5,
    OP_BOOT   = 3'd6,
    OP_RSVD   = 3'd7
  } cmd_op_e;

  typedef enum logic [2:0] {
    CAUSE_BOOT   = 3'd0,
    CAUSE_HOST   = 3'd1,
    CAUSE_STEP   = 3'd2,
    CAUSE_BP     = 3'd3,
    CAUSE_EBREAK = 3'd4
  } halt_cause_e;

  typedef enum logic [2:0] {
    ST_RESET_HOLD = 3'd0,
    ST_PRESET     = 3'd1,
    ST_HALTED     = 3'd2,
    ST_RUN        = 3'd3,
    ST_STEP       = 3'd4
  } state_e;

  localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;

endpackage

// File: rtl/retire_counter.sv
// Retired-instruction counter.
// Ports: clk, rst (async, active-high), en (count this posedge),
//        cnt (current count, wraps modulo 2^CNT_W).
module retire_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/core_run_ctrl.sv
// Run/debug controller sequencing a single-cycle RV32I datapath.
// Ports:
//   clk, rst                 : clock, async active-high reset
//   cmd_valid/cmd_ready      : host command handshake
//   cmd_op, cmd_data         : command opcode and argument
//   instr, pc                : observed datapath instruction and current PC
//   dp_rst, dp_preset        : datapath reset / PC preset
//   dp_hlt                   : datapath clock gate (1 = frozen), negedge flop
//   start_addr               : datapath preset address (boot address register)
//   halted, halt_cause       : halted status and reason
//   cmd_err                  : one-cycle pulse for an accepted-but-ignored command
//   retire_cnt               : executed datapath edges
module core_run_ctrl
  import core_dbg_pkg::*;
#(
  parameter int unsigned RESET_CYCLES = 4,
  parameter logic [31:0] BOOT_ADDR    = 32'h0000_0000,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [31:0]      cmd_data,
  input  logic [31:0]      instr,
  input  logic [31:0]      pc,
  output logic             dp_rst,
  output logic             dp_preset,
  output logic             dp_hlt,
  output logic [31:0]      start_addr,
  output logic             halted,
  output logic [2:0]       halt_cause,
  output logic             cmd_err,
  output logic [CNT_W-1:0] retire_cnt
);

  state_e      state_q, state_d;
  logic [31:0] hold_cnt_q, hold_cnt_d;
  logic [31:0] boot_addr_q, boot_addr_d;
  logic [31:0] bp_addr_q, bp_addr_d;
  logic        bp_en_q, bp_en_d;
  halt_cause_e halt_cause_q, halt_cause_d;
  logic        cmd_err_q, cmd_err_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        dp_rst_q, dp_rst_d;
  logic        dp_preset_q, dp_preset_d;
  logic        hlt_q, hlt_d;
  logic        step_over_q, step_over_d;
  logic        dp_hlt_q, dp_hlt_d;

  cmd_op_e op;
  logic    accept;
  logic    bp_hit;
  logic    ebreak_hit;
  logic    stop_eff;

  always_comb begin
    op         = cmd_op_e'(cmd_op);
    accept     = cmd_valid && cmd_ready_q;
    bp_hit     = bp_en_q && (pc == bp_addr_q);
    ebreak_hit = (instr == EBREAK_INSTR);
    // The first instruction after entering RUN/STEP is always executed so
    // resuming on a breakpoint or EBREAK makes progress.
    stop_eff   = (state_q == ST_RUN) && !step_over_q && (bp_hit || ebreak_hit);
    dp_hlt_d   = hlt_q || stop_eff;
  end

  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    boot_addr_d  = boot_addr_q;
    bp_addr_d    = bp_addr_q;
    bp_en_d      = bp_en_q;
    halt_cause_d = halt_cause_q;
    cmd_err_d    = 1'b0;
    step_over_d  = 1'b0;

    case (state_q)
      ST_RESET_HOLD: begin
        if (hold_cnt_q == RESET_CYCLES - 1) begin
          state_d    = ST_PRESET;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + 32'd1;
        end
      end
      ST_PRESET: begin
        state_d      = ST_HALTED;
        halt_cause_d = CAUSE_BOOT;
      end
      ST_HALTED: begin
        if (accept) begin
          case (op)
            OP_RUN: begin
              state_d     = ST_RUN;
              step_over_d = 1'b1;
            end
            OP_STEP: begin
              state_d     = ST_STEP;
              step_over_d = 1'b1;
            end
            OP_SET_BP: begin
              bp_addr_d = cmd_data;
              bp_en_d   = 1'b1;
            end
            OP_CLR_BP: bp_en_d = 1'b0;
            OP_BOOT: begin
              boot_addr_d = cmd_data;
              hold_cnt_d  = '0;
              state_d     = ST_RESET_HOLD;
            end
            OP_HALT: cmd_err_d = 1'b1;
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        // A stop seen on this edge outranks a host HALT on the same edge.
        if (stop_eff) begin
          state_d      = ST_HALTED;
          halt_cause_d = bp_hit ? CAUSE_BP : CAUSE_EBREAK;
        end else if (accept && op == OP_HALT) begin
          state_d      = ST_HALTED;
          halt_cause_d = CAUSE_HOST;
        end
        if (accept && op != OP_NOP && op != OP_HALT && op != OP_RSVD) cmd_err_d = 1'b1;
      end
      ST_STEP: begin
        state_d      = ST_HALTED;
        halt_cause_d = CAUSE_STEP;
      end
      default: state_d = ST_RESET_HOLD;
    endcase

    dp_rst_d    = (state_d == ST_RESET_HOLD);
    dp_preset_d = (state_d == ST_PRESET);
    hlt_d       = !((state_d == ST_RUN) || (state_d == ST_STEP));
    cmd_ready_d = (state_d == ST_HALTED) || (state_d == ST_RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_RESET_HOLD;
      hold_cnt_q   <= '0;
      boot_addr_q  <= BOOT_ADDR;
      bp_addr_q    <= '0;
      bp_en_q      <= 1'b0;
      halt_cause_q <= CAUSE_BOOT;
      cmd_err_q    <= 1'b0;
      cmd_ready_q  <= 1'b0;
      dp_rst_q     <= 1'b1;
      dp_preset_q  <= 1'b0;
      hlt_q        <= 1'b1;
      step_over_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      boot_addr_q  <= boot_addr_d;
      bp_addr_q    <= bp_addr_d;
      bp_en_q      <= bp_en_d;
      halt_cause_q <= halt_cause_d;
      cmd_err_q    <= cmd_err_d;
      cmd_ready_q  <= cmd_ready_d;
      dp_rst_q     <= dp_rst_d;
      dp_preset_q  <= dp_preset_d;
      hlt_q        <= hlt_d;
      step_over_q  <= step_over_d;
    end
  end

  // Clock gate updates only while clk is low, keeping the gated clock clean.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) dp_hlt_q <= 1'b1;
    else     dp_hlt_q <= dp_hlt_d;
  end

  retire_counter #(.CNT_W(CNT_W)) u_retire_counter (
    .clk (clk),
    .rst (rst),
    .en  (!dp_hlt_q),
    .cnt (retire_cnt)
  );

  assign cmd_ready  = cmd_ready_q;
  assign dp_rst     = dp_rst_q;
  assign dp_preset  = dp_preset_q;
  assign dp_hlt     = dp_hlt_q;
  assign start_addr = boot_addr_q;
  assign halted     = (state_q == ST_HALTED);
  assign halt_cause = halt_cause_q;
  assign cmd_err    = cmd_err_q;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Directed self-checking bench for core_run_ctrl with a behavioural datapath
// PC model (async rst/preset, +4 per ungated posedge).
module tb_core_run_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = 3'd0;
  logic [31:0] cmd_data = '0;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        dp_rst, dp_preset, dp_hlt;
  logic [31:0] start_addr;
  logic        halted;
  logic [2:0]  halt_cause;
  logic        cmd_err;
  logic [31:0] retire_cnt;

  logic        ebreak_mode = 1'b0;
  int          exec_cnt = 0;
  int          passed = 0;
  int          total = 0;

  core_run_ctrl #(.RESET_CYCLES(4), .BOOT_ADDR(32'h0), .CNT_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_data   (cmd_data),
    .instr      (instr),
    .pc         (pc),
    .dp_rst     (dp_rst),
    .dp_preset  (dp_preset),
    .dp_hlt     (dp_hlt),
    .start_addr (start_addr),
    .halted     (halted),
    .halt_cause (halt_cause),
    .cmd_err    (cmd_err),
    .retire_cnt (retire_cnt)
  );

  always #5 clk = ~clk;

  // Datapath PC model
  always @(posedge clk or posedge dp_rst or posedge dp_preset) begin
    if (dp_rst)         pc <= 32'h0;
    else if (dp_preset) pc <= start_addr;
    else if (!dp_hlt)   pc <= pc + 32'd4;
  end

  always @(posedge clk) begin
    if (!dp_hlt && !dp_rst && !dp_preset) exec_cnt <= exec_cnt + 1;
  end

  assign instr = (ebreak_mode && pc == 32'h8) ? 32'h0010_0073 : 32'h0000_0013;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [2:0] op, input logic [31:0] data);
    int n;
    n = 0;
    while (!cmd_ready && n < 50) begin
      tick();
      n++;
    end
    if (!cmd_ready) chk("cmd_ready_timeout", {63'd0, cmd_ready}, 64'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    tick();
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_data  = '0;
  endtask

  task automatic wait_halted(input string tag, input int max, output int n);
    n = 0;
    while (!halted && n < max) begin
      tick();
      n++;
    end
    chk(tag, {63'd0, halted}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int e0;

    // Reset state
    tick();
    tick();
    chk("rst_dp_rst",    dp_rst, 1);
    chk("rst_dp_preset", dp_preset, 0);
    chk("rst_dp_hlt",    dp_hlt, 1);
    chk("rst_halted",    halted, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_retire",    retire_cnt, 0);
    chk("rst_cause",     halt_cause, 0);
    chk("rst_cmd_err",   cmd_err, 0);
    rst = 1'b0;

    // Boot timing: 4 edges in reset hold, one in preset
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("boot_hold_dp_rst", dp_rst, 1);
      chk("boot_hold_dp_hlt", dp_hlt, 1);
    end
    tick();
    chk("boot_dp_rst_off", dp_rst, 0);
    chk("boot_preset",     dp_preset, 1);
    chk("boot_start_addr", start_addr, 32'h0);
    chk("boot_pre_dp_hlt", dp_hlt, 1);
    tick();
    chk("boot_preset_off", dp_preset, 0);
    chk("boot_halted",     halted, 1);
    chk("boot_cause",      halt_cause, 0);
    chk("boot_dp_hlt",     dp_hlt, 1);
    chk("boot_cmd_ready",  cmd_ready, 1);

    // HALT while halted is ignored with an error pulse
    cmd(3'd2, 32'h0);
    chk("halt_in_halted_err", cmd_err, 1);
    tick();
    chk("halt_in_halted_err_off", cmd_err, 0);
    chk("halt_in_halted_state", halted, 1);

    // BOOT 0x100 then three single steps
    cmd(3'd6, 32'h100);
    chk("bootcmd_left_halted", halted, 0);
    wait_halted("bootcmd_halted", 20, n);
    chk("bootcmd_start_addr", start_addr, 32'h100);
    chk("bootcmd_pc", pc, 32'h100);
    for (int s = 0; s < 3; s++) begin
      e0 = exec_cnt;
      cmd(3'd3, 32'h0);
      wait_halted("step_halted", 10, n);
      tick();
      chk("step_one_edge", exec_cnt - e0, 1);
      chk("step_dp_hlt", dp_hlt, 1);
    end
    chk("step_retire", retire_cnt, 3);
    chk("step_cause", halt_cause, 2);
    chk("step_pc", pc, 32'h10C);

    // Reset again to start the breakpoint test from PC 0 with a clean counter
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_halted("reboot_halted", 20, n);
    chk("reboot_pc", pc, 32'h0);

    // Breakpoint at 0x10
    cmd(3'd4, 32'h10);
    cmd(3'd1, 32'h0);
    wait_halted("bp_halted", 30, n);
    chk("bp_pc", pc, 32'h10);
    chk("bp_retire", retire_cnt, 4);
    chk("bp_cause", halt_cause, 3);

    // Resume over the breakpoint, then HALT
    cmd(3'd1, 32'h0);
    tick();
    tick();
    tick();
    chk("resume_pc", pc, 32'h1C);
    chk("resume_retire", retire_cnt, 7);
    cmd(3'd2, 32'h0);
    tick();
    chk("host_halt_pc", pc, 32'h20);
    chk("host_halt_retire", retire_cnt, 8);
    chk("host_halt_cause", halt_cause, 1);
    chk("host_halt_halted", halted, 1);

    // STEP during RUN gives an error pulse and leaves RUN unchanged
    cmd(3'd1, 32'h0);
    cmd(3'd3, 32'h0);
    chk("run_step_err", cmd_err, 1);
    chk("run_step_not_halted", halted, 0);
    tick();
    chk("run_step_err_off", cmd_err, 0);
    chk("run_step_pc", pc, 32'h28);
    cmd(3'd2, 32'h0);
    tick();
    chk("run2_halt_retire", retire_cnt, 11);

    // HALT on the same edge as a breakpoint stop
    cmd(3'd4, 32'h38);
    cmd(3'd1, 32'h0);
    tick();
    tick();
    tick();
    cmd(3'd2, 32'h0);
    chk("bp_vs_halt_halted", halted, 1);
    chk("bp_vs_halt_cause", halt_cause, 3);
    chk("bp_vs_halt_pc", pc, 32'h38);
    chk("bp_vs_halt_retire", retire_cnt, 14);

    // EBREAK at 0x8
    cmd(3'd5, 32'h0);
    ebreak_mode = 1'b1;
    cmd(3'd6, 32'h0);
    wait_halted("eb_boot_halted", 20, n);
    cmd(3'd1, 32'h0);
    wait_halted("eb_halted", 20, n);
    chk("eb_pc", pc, 32'h8);
    chk("eb_cause", halt_cause, 4);
    chk("eb_retire", retire_cnt, 16);
    cmd(3'd3, 32'h0);
    wait_halted("eb_step_halted", 10, n);
    tick();
    chk("eb_step_pc", pc, 32'hC);
    chk("eb_step_retire", retire_cnt, 17);
    chk("eb_step_cause", halt_cause, 2);

    // Reset in the middle of RUN
    cmd(3'd1, 32'h0);
    tick();
    tick();
    chk("midrun_running", dp_hlt, 0);
    rst = 1'b1;
    #1;
    chk("midrun_rst_dp_hlt", dp_hlt, 1);
    chk("midrun_rst_dp_rst", dp_rst, 1);
    chk("midrun_rst_retire", retire_cnt, 0);
    chk("midrun_rst_halted", halted, 0);
    chk("midrun_rst_cmd_ready", cmd_ready, 0);
    tick();
    rst = 1'b0;
    wait_halted("midrun_reboot_halted", 20, n);
    chk("midrun_reboot_edges", n, 5);
    chk("midrun_reboot_pc", pc, 32'h0);
    chk("midrun_reboot_cause", halt_cause, 0);
    chk("midrun_reboot_dp_hlt", dp_hlt, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/core_run_ctrl.md
# core_run_ctrl

Run/debug controller that sequences the single-cycle RV32I datapath. It drives the datapath's `rst`, `preset`, `hlt` and `start_addr` inputs to provide:
- a timed boot (reset hold, then PC preset);
- host-commanded run, halt and single-step;
- a PC breakpoint and halt-before-EBREAK;
- a retired-instruction counter.

It sits between the host/debug port and the datapath, and observes the datapath's `instr` and exported current PC.

## Interface
- `RESET_CYCLES`, 4: number of cycles `dp_rst` is held after `rst` deasserts (≥1).
- `BOOT_ADDR`, 32'h0000_0000: reset value of the boot address register.
- `CNT_W`, 32: width of `retire_cnt`.

- `clk` in 1: the single clock, also the datapath's `clk_in`.
- `rst` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1: host command valid.
- `cmd_ready` out 1: a command is accepted on a posedge where `cmd_valid && cmd_ready`.
- `cmd_op` in 3: 0 NOP, 1 RUN, 2 HALT, 3 STEP, 4 SET_BP, 5 CLR_BP, 6 BOOT; 7 is treated as NOP.
- `cmd_data` in 32: breakpoint address for SET_BP, boot address for BOOT.
- `instr` in 32: datapath instruction at the current PC.
- `pc` in 32: datapath current PC.
- `dp_rst` out 1: datapath reset.
- `dp_preset` out 1: datapath PC preset.
- `dp_hlt` out 1: datapath clock gate (1 = frozen).
- `start_addr` out 32: datapath preset address, equal to the boot address register.
- `halted` out 1: controller is in HALTED.
- `halt_cause` out 3: 0 BOOT, 1 HOST, 2 STEP, 3 BP, 4 EBREAK.
- `cmd_err` out 1: one-cycle pulse when an accepted command is ignored.
- `retire_cnt` out CNT_W: count of executed datapath edges.

## Operation
- States:
  - RESET_HOLD: `dp_rst`=1, counter runs.
  - PRESET: `dp_preset`=1 for one cycle.
  - HALTED.
  - RUN.
  - STEP.
- Reset values under `rst`:
  - state RESET_HOLD, hold counter 0, `dp_rst`=1, `dp_preset`=0, `dp_hlt`=1, `hlt_q`=1.
  - boot address = `BOOT_ADDR`, `bp_en`=0, `bp_addr`=0.
  - `halt_cause`=0, `retire_cnt`=0, `cmd_err`=0, `cmd_ready`=0.
- RESET_HOLD goes to PRESET after `RESET_CYCLES` posedges. PRESET goes to HALTED (cause BOOT) after one posedge.
- The datapath PC treats `rst`/`preset` as asynchronous level inputs, so `dp_hlt` stays 1 throughout boot.
- `cmd_ready`=1 only in HALTED and RUN.
- Commands accepted in HALTED:
  - RUN → RUN.
  - STEP → STEP.
  - SET_BP: `bp_addr`=`cmd_data`, `bp_en`=1.
  - CLR_BP: `bp_en`=0.
  - BOOT: boot address=`cmd_data`, then → RESET_HOLD.
  - HALT: `cmd_err` pulse, no other effect.
- Commands accepted in RUN:
  - HALT → HALTED, cause HOST.
  - Any other non-NOP op: ignored with a `cmd_err` pulse.
- Stop detection, evaluated combinationally on the current `pc`/`instr` in RUN: `stop` = (`bp_en` && `pc`==`bp_addr`) || `instr`==32'h0010_0073 (EBREAK).
  - Stop is suppressed for the first instruction after entry to RUN or STEP (step-over flag), so resuming on a breakpoint or EBREAK makes progress.
- Stop priority: BP > EBREAK > HOST.
- STEP: exactly one datapath edge executes, then → HALTED, cause STEP.
- `retire_cnt` increments on every posedge where `dp_hlt`==0 and wraps modulo 2^`CNT_W`.

## Timing
- `hlt_q` is computed at posedge. `dp_hlt` is a falling-edge flop loading `hlt_q || stop_eff`, so it only changes while `clk` is low. This keeps the datapath's gated clock glitch-free.
- The datapath executes the instruction at `pc` on any posedge where `dp_hlt`==0.
- RUN accepted at posedge E0:
  - `dp_hlt` falls at the following negedge.
  - The first instruction executes at E1.
- STEP accepted at E0:
  - Executes at E1.
  - State is HALTED and `hlt_q`=1 from E1.
  - `dp_hlt` rises at the negedge after E1.
- HALT accepted at E0 in RUN: the instruction at E0 still executes, none at E1.
- Breakpoint/EBREAK:
  - At the negedge before edge Ek, if `stop`, `dp_hlt` goes 1 and Ek does not execute.
  - At Ek the state goes to HALTED with the cause recorded.
  - The breakpoint instruction itself is not executed.
- HALT accepted on the same edge as a stop: cause is BP/EBREAK, not HOST.
- `rst` mid-RUN: all outputs return to reset values immediately, including `dp_hlt`=1 asynchronously, and boot restarts.
- `cmd_err` is a single-cycle pulse, registered at the accept edge.

## Structure
- Shared package `core_dbg_pkg`: `cmd_op` encodings, `halt_cause` encodings, state enum, and the EBREAK constant 32'h0010_0073.
- One natural sub-module: `retire_counter` (enable, wrap, async reset).
- The rest is a single FSM plus the negedge `dp_hlt` flop.

## Test plan
- Reset, `RESET_CYCLES`=4: `dp_rst`=1 for 4 posedges after `rst` falls, then `dp_preset`=1 for 1 cycle with `start_addr`=0, then `halted`=1 with `halt_cause`=0 and `dp_hlt`=1 throughout.
- BOOT with `cmd_data`=32'h100, then STEP ×3: `start_addr`=32'h100, `retire_cnt`=3, `halt_cause`=2, and each step yields exactly one `dp_hlt`-low cycle.
- SET_BP 32'h10, then RUN from PC 0 with linear code: halts with `pc`=32'h10, `retire_cnt`=4, `halt_cause`=3; a second RUN executes 32'h10 and continues.
- EBREAK at 32'h8: RUN halts with `pc`=32'h8 and `halt_cause`=4; STEP executes the EBREAK (`pc` advances, `retire_cnt`+1).
- RUN, then HALT accepted at E0: the instruction at E0 counts and E1 does not; STEP issued during RUN gives a `cmd_err` pulse with state unchanged. Then HALT on the same edge as a breakpoint stop gives `halt_cause`=3.
- Assert `rst` while in RUN: `dp_hlt`=1 and `dp_rst`=1 in the same cycle, `retire_cnt`=0, and the boot sequence repeats.
